// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state encoding and default geometry constants
// used by the MISR checker and the LFSR pattern generators.
package bist_pkg;

    localparam int          BIST_WIDTH = 16;
    localparam int          BIST_CNT_W = 16;
    localparam logic [15:0] BIST_POLY  = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } bist_state_e;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: reseedable, shifts one response word per
// enabled cycle with internal-XOR feedback from the MSB.
module misr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sig_o
);

    logic [WIDTH-1:0] misr_q;
    logic [WIDTH-1:0] misr_d;
    logic [WIDTH-1:0] tap_mask_s;
    logic             fb_s;

    // Bit 0 always takes the feedback, whatever POLY[0] says.
    assign tap_mask_s = POLY | {{(WIDTH-1){1'b0}}, 1'b1};
    assign fb_s       = misr_q[WIDTH-1];

    // Next-state selection: reseed wins over a shift.
    always_comb begin
        misr_d = misr_q;
        if (load_i) begin
            misr_d = SEED;
        end else if (shift_i) begin
            misr_d = {misr_q[WIDTH-2:0], 1'b0} ^ data_i ^ (tap_mask_s & {WIDTH{fb_s}});
        end else begin
            misr_d = misr_q;
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr_q <= SEED;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign sig_o = misr_q;

endmodule

// File: rtl/bist_misr_checker.sv
// BIST response compaction and verdict: compacts CUT words into a MISR while a
// run is active and checks signature and vector count on bist_end.
module bist_misr_checker
    import bist_pkg::*;
#(
    parameter int               WIDTH     = BIST_WIDTH,
    parameter logic [WIDTH-1:0] POLY      = BIST_POLY,
    parameter logic [WIDTH-1:0] SEED      = '0,
    parameter logic [WIDTH-1:0] GOLDEN    = '0,
    parameter int               N_VECTORS = 256,
    parameter int               CNT_W     = BIST_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             capture_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             bist_end,
    output logic             busy,
    output logic             done,
    output logic             pass_nfail,
    output logic [WIDTH-1:0] signature
);

    bist_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             prev_start_q;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             start_rise_s;
    logic             load_s;
    logic             shift_s;

    assign start_rise_s = start & ~prev_start_q;

    // FSM, vector counter and verdict next-state logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        pass_d  = pass_q;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_rise_s) begin
                    load_s  = 1'b1;
                    count_d = {CNT_W{1'b0}};
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = ST_COMPACT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_COMPACT: begin
                if (start_rise_s) begin
                    load_s  = 1'b1;
                    count_d = {CNT_W{1'b0}};
                end else begin
                    if (capture_en) begin
                        shift_s = 1'b1;
                        // Saturate rather than wrap so an over-long run still fails.
                        count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        shift_s = 1'b0;
                    end
                    if (bist_end) begin
                        state_d = ST_COMPARE;
                    end else begin
                        state_d = ST_COMPACT;
                    end
                end
            end
            ST_COMPARE: begin
                pass_d  = (signature == GOLDEN) && (count_q == CNT_W'(N_VECTORS));
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_COMPACT) || (state_d == ST_COMPARE);
    end

    // Control and verdict registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            count_q      <= {CNT_W{1'b0}};
            prev_start_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            prev_start_q <= start;
            done_q       <= done_d;
            pass_q       <= pass_d;
            busy_q       <= busy_d;
        end
    end

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (load_s),
        .shift_i (shift_s),
        .data_i  (data_in),
        .sig_o   (signature)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_nfail = pass_q;

endmodule

// File: tb/tb_bist_misr_checker.sv
// Directed bench for bist_misr_checker: two 8-bit instances with different
// seed/golden settings, hand-computed signatures and verdicts.
module tb_bist_misr_checker;

    logic       clk;
    logic       reset;
    logic       a_start, a_cap, a_end;
    logic [7:0] a_data;
    logic       a_busy, a_done, a_pass;
    logic [7:0] a_sig;
    logic       b_start, b_cap, b_end;
    logic [7:0] b_data;
    logic       b_busy, b_done, b_pass;
    logic [7:0] b_sig;

    int n_cmp;
    int n_bad;

    bist_misr_checker #(
        .WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h03), .N_VECTORS(2), .CNT_W(8)
    ) u_a (
        .clk(clk), .reset(reset), .start(a_start), .capture_en(a_cap), .data_in(a_data),
        .bist_end(a_end), .busy(a_busy), .done(a_done), .pass_nfail(a_pass), .signature(a_sig)
    );

    bist_misr_checker #(
        .WIDTH(8), .POLY(8'h1D), .SEED(8'h80), .GOLDEN(8'h1D), .N_VECTORS(2), .CNT_W(8)
    ) u_b (
        .clk(clk), .reset(reset), .start(b_start), .capture_en(b_cap), .data_in(b_data),
        .bist_end(b_end), .busy(b_busy), .done(b_done), .pass_nfail(b_pass), .signature(b_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        a_start = 1'b0; a_cap = 1'b0; a_end = 1'b0; a_data = 8'h00;
        b_start = 1'b0; b_cap = 1'b0; b_end = 1'b0; b_data = 8'h00;
        step(); step();
        chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_a_done", {31'd0, a_done}, 32'd0);
        chk("rst_a_pass", {31'd0, a_pass}, 32'd0);
        chk("rst_a_sig", {24'd0, a_sig}, 32'h00);
        chk("rst_b_sig", {24'd0, b_sig}, 32'h80);
        reset = 1'b1;
        step();

        // bist_end and capture_en in IDLE are ignored
        a_end = 1'b1;
        step();
        a_end = 1'b0;
        chk("idle_end_busy", {31'd0, a_busy}, 32'd0);
        chk("idle_end_done", {31'd0, a_done}, 32'd0);
        a_cap = 1'b1; a_data = 8'h55;
        step();
        a_cap = 1'b0;
        chk("idle_cap_sig", {24'd0, a_sig}, 32'h00);
        chk("idle_cap_busy", {31'd0, a_busy}, 32'd0);

        // Passing run: 01, 01 (second with bist_end) -> 03, count 2
        a_start = 1'b1;
        step();
        chk("s2_busy", {31'd0, a_busy}, 32'd1);
        a_cap = 1'b1; a_data = 8'h01;
        step();
        chk("s2_sig1", {24'd0, a_sig}, 32'h01);
        a_end = 1'b1;
        step();
        chk("s2_sig2", {24'd0, a_sig}, 32'h03);
        chk("s2_t1_done", {31'd0, a_done}, 32'd0);
        chk("s2_t1_busy", {31'd0, a_busy}, 32'd1);
        a_end = 1'b0; a_data = 8'hFF;
        step();
        a_cap = 1'b0;
        chk("s2_t2_done", {31'd0, a_done}, 32'd1);
        chk("s2_t2_pass", {31'd0, a_pass}, 32'd1);
        chk("s2_t2_busy", {31'd0, a_busy}, 32'd0);
        chk("s2_cmp_nocap", {24'd0, a_sig}, 32'h03);

        // capture_en and bist_end in DONE are ignored
        a_cap = 1'b1; a_data = 8'hAA;
        step();
        a_cap = 1'b0;
        chk("done_cap_sig", {24'd0, a_sig}, 32'h03);
        a_end = 1'b1;
        step();
        a_end = 1'b0;
        chk("done_end_done", {31'd0, a_done}, 32'd1);
        chk("done_end_busy", {31'd0, a_busy}, 32'd0);

        // Failing run: 01 then 00 -> 02
        a_start = 1'b0;
        step();
        a_start = 1'b1;
        step();
        chk("s4_done_clr", {31'd0, a_done}, 32'd0);
        chk("s4_reseed", {24'd0, a_sig}, 32'h00);
        a_cap = 1'b1; a_data = 8'h01;
        step();
        a_data = 8'h00; a_end = 1'b1;
        step();
        chk("s4_sig", {24'd0, a_sig}, 32'h02);
        a_cap = 1'b0; a_end = 1'b0;
        step();
        step();
        chk("s4_done", {31'd0, a_done}, 32'd1);
        chk("s4_pass", {31'd0, a_pass}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("s4_hold_done", {31'd0, a_done}, 32'd1);
            chk("s4_hold_pass", {31'd0, a_pass}, 32'd0);
        end
        chk("s4_hold_sig", {24'd0, a_sig}, 32'h02);

        // Restart mid-run; capture coincident with the restart edge is dropped
        a_start = 1'b0;
        step();
        a_start = 1'b1;
        step();
        a_cap = 1'b1; a_data = 8'h01;
        step();
        chk("s5_sig_pre", {24'd0, a_sig}, 32'h01);
        a_cap = 1'b0; a_start = 1'b0;
        step();
        a_start = 1'b1; a_cap = 1'b1;
        step();
        chk("s5_reseed", {24'd0, a_sig}, 32'h00);
        step();
        chk("s5_sig1", {24'd0, a_sig}, 32'h01);
        a_end = 1'b1;
        step();
        chk("s5_sig2", {24'd0, a_sig}, 32'h03);
        a_cap = 1'b0; a_end = 1'b0;
        step();
        step();
        chk("s5_done", {31'd0, a_done}, 32'd1);
        chk("s5_pass", {31'd0, a_pass}, 32'd1);
        a_start = 1'b0;
        step();
        a_start = 1'b1;
        step();
        chk("s5_done_clr", {31'd0, a_done}, 32'd0);
        chk("s5_pass_clr", {31'd0, a_pass}, 32'd0);

        // Seed 80, one capture of 00 -> 1D, count mismatch fails
        b_start = 1'b1;
        step();
        b_cap = 1'b1; b_data = 8'h00;
        step();
        chk("s3_sig", {24'd0, b_sig}, 32'h1D);
        b_cap = 1'b0; b_end = 1'b1;
        step();
        b_end = 1'b0;
        step();
        chk("s3_done", {31'd0, b_done}, 32'd1);
        chk("s3_pass", {31'd0, b_pass}, 32'd0);
        chk("s3_busy", {31'd0, b_busy}, 32'd0);

        // Reset mid-COMPACT aborts at once
        b_start = 1'b0;
        step();
        b_start = 1'b1;
        step();
        b_cap = 1'b1; b_data = 8'h5A;
        step();
        chk("s1_sig_run", {24'd0, b_sig}, 32'h47);
        chk("s1_busy_run", {31'd0, b_busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("s1_busy", {31'd0, b_busy}, 32'd0);
        chk("s1_done", {31'd0, b_done}, 32'd0);
        chk("s1_pass", {31'd0, b_pass}, 32'd0);
        chk("s1_sig", {24'd0, b_sig}, 32'h80);
        chk("s1_a_done", {31'd0, a_done}, 32'd0);
        step();
        chk("s1_sig_hold", {24'd0, b_sig}, 32'h80);
        a_start = 1'b0; b_start = 1'b0;
        reset = 1'b1;
        step();
        step();
        chk("s1_post_sig", {24'd0, b_sig}, 32'h80);
        chk("s1_post_busy", {31'd0, b_busy}, 32'd0);
        chk("s1_post_done", {31'd0, b_done}, 32'd0);
        b_cap = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bist_misr_checker.md
Name: bist_misr_checker

Overview:
Response-compaction and verdict stage downstream of the BIST controller and the 7b/9b LFSR pattern generators.
- Compresses the circuit-under-test response words into a MISR signature while a BIST run is active.
- On the controller's bist_end, compares the signature and the captured-vector count against golden values.
- Drives the registered done/pass_nfail verdict that the top level exports.

Parameters:
WIDTH, 16, MISR and response word width (>=2)
POLY, 16'h1021, feedback tap mask; bit i set means the MSB feedback is XORed into bit i (bit 0 always fed back)
SEED, 16'h0000, MISR value loaded at run start
GOLDEN, 16'h0000, expected final signature
N_VECTORS, 256, expected number of captured words per run
CNT_W, 16, vector counter width

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; low forces reset state immediately
start  in  1  BIST start level, the same signal that feeds the controller; rising edge detected internally
capture_en  in  1  response word valid this cycle
data_in  in  WIDTH  CUT response word
bist_end  in  1  end-of-run pulse from the BIST controller
busy  out  1  high while compacting or comparing
done  out  1  verdict valid; level, held until next run
pass_nfail  out  1  1 = signature and count match, 0 = fail or not yet decided
signature  out  WIDTH  current MISR contents

Behaviour:
Reset (reset=0, asynchronous):
- state=IDLE, misr=SEED, count=0, prev_start=0.
- busy=0, done=0, pass_nfail=0.

Start detection:
- prev_start registers start every cycle.
- start_rise = start & ~prev_start.

MISR update (only when state=COMPACT and capture_en=1):
- fb = misr[WIDTH-1].
- next[0] = fb ^ data_in[0].
- next[i] = misr[i-1] ^ data_in[i] ^ (POLY[i] & fb), for i = 1..WIDTH-1.
- count increments and saturates at 2^CNT_W-1 (no wrap).

FSM:
- IDLE: on start_rise, load misr=SEED, count=0, done=0, pass_nfail=0, go to COMPACT.
- COMPACT, busy=1:
  - Compacts on each capture_en.
  - If bist_end=1, the capture in that same cycle is still taken, then go to COMPARE.
  - A start_rise here restarts the run: reseed, count=0, stay in COMPACT; start_rise wins over bist_end in the same cycle.
- COMPARE, busy=1, single cycle:
  - pass_nfail <= (misr==GOLDEN) && (count==N_VECTORS).
  - done <= 1, go to DONE.
  - capture_en is ignored.
- DONE, busy=0:
  - done and pass_nfail hold, signature frozen.
  - start_rise takes the same action as from IDLE.

Timing and edge cases:
- Latency: bist_end high in cycle t gives done=1 and pass_nfail valid from cycle t+2.
- bist_end in IDLE or DONE is ignored. capture_en outside COMPACT is ignored.
- start held high does not retrigger; only a new 0->1 edge does.
- Reset asserted mid-run aborts immediately; no verdict is produced.

Decomposition:
- Shared package bist_pkg holds:
  - the state enum (IDLE, COMPACT, COMPARE, DONE);
  - default WIDTH, CNT_W and POLY constants, reused by the LFSR blocks.
- One sub-module, misr_core: WIDTH/POLY/SEED register with load (seed) and shift enable, asynchronous active-low reset, outputting the signature.
- FSM, counter and verdict logic stay in bist_misr_checker.

Test Plan (WIDTH=8, POLY=8'h1D, CNT_W=8 unless noted):
1. Reset low mid-COMPACT -> same cycle busy=0, done=0, pass_nfail=0, signature=SEED; ignores further capture_en.
2. SEED=0, GOLDEN=8'h03, N_VECTORS=2; start rise, two captures of 8'h01, bist_end pulse -> signature 8'h01 then 8'h03; done=1 and pass_nfail=1 two cycles after bist_end.
3. SEED=8'h80, one capture of 8'h00 -> signature 8'h1D (feedback taps applied); with GOLDEN=8'h1D, N_VECTORS=2 -> done=1, pass_nfail=0 (count mismatch).
4. As scenario 2, but the second word is 8'h00 -> signature 8'h02, pass_nfail=0, done=1; verdict held for 20 cycles with start held high.
5. Start rise mid-run after 1 capture, then two 8'h01 captures and bist_end -> count=2, pass_nfail=1 (restart reseeded); the next start rise in DONE clears done within 1 cycle.
6. bist_end asserted in IDLE, and capture_en asserted in DONE -> no state change, signature unchanged.
